// File: rtl/exec_pkg.sv
// Shared definitions for the execute unit: FSM state encoding, the decoded
// operation select and the default datapath/address widths.
package exec_pkg;

  localparam int DWIDTH_DEF     = 16;
  localparam int ADDR_WIDTH_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_ALU    = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE    = 4'd0,
    OP_ADD     = 4'd1,
    OP_LOAD    = 4'd2,
    OP_STORE   = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_ISZ     = 4'd5,
    OP_CLR_AC  = 4'd6,
    OP_CLR_E   = 4'd7,
    OP_COMP_AC = 4'd8,
    OP_LOAD_AC = 4'd9,
    OP_CIR_R   = 4'd10,
    OP_CIR_L   = 4'd11,
    OP_INC_AC  = 4'd12
  } op_t;

  // Strobe vector bit order: [0]=add .. [11]=inc_ac, lowest bit wins.
  function automatic op_t op_select(input logic [11:0] stb);
    if (stb[0])       return OP_ADD;
    else if (stb[1])  return OP_LOAD;
    else if (stb[2])  return OP_STORE;
    else if (stb[3])  return OP_BRANCH;
    else if (stb[4])  return OP_ISZ;
    else if (stb[5])  return OP_CLR_AC;
    else if (stb[6])  return OP_CLR_E;
    else if (stb[7])  return OP_COMP_AC;
    else if (stb[8])  return OP_LOAD_AC;
    else if (stb[9])  return OP_CIR_R;
    else if (stb[10]) return OP_CIR_L;
    else if (stb[11]) return OP_INC_AC;
    else              return OP_NONE;
  endfunction

endpackage

// File: rtl/exec_if.sv
// Memory bus between the execute unit (master) and the memory (slave).
// Read and write requests are held until the slave answers with ready.
interface exec_if
  import exec_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  o_mem_read;
  logic                  o_mem_write;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DWIDTH-1:0]     o_mem_wdata;
  logic [DWIDTH-1:0]     i_mem_rdata;
  logic                  i_mem_ready;

  modport master (
    output o_mem_read,
    output o_mem_write,
    output o_mem_addr,
    output o_mem_wdata,
    input  i_mem_rdata,
    input  i_mem_ready
  );

  modport slave (
    input  o_mem_read,
    input  o_mem_write,
    input  o_mem_addr,
    input  o_mem_wdata,
    output i_mem_rdata,
    output i_mem_ready
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational next-value logic for the architectural AC and E registers,
// plus the incremented memory operand used by ISZ write-back.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  op_t               op,
  input  logic [DWIDTH-1:0] ac,
  input  logic              e,
  input  logic [DWIDTH-1:0] data,
  input  logic [7:0]        imm,
  output logic [DWIDTH-1:0] ac_nxt,
  output logic              e_nxt,
  output logic [DWIDTH-1:0] tmp
);

  localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);

  logic [DWIDTH:0] sum;

  assign sum = {1'b0, ac} + {1'b0, data};
  assign tmp = data + ONE;

  // AC/E hold their value unless the selected op redefines them.
  always_comb begin
    ac_nxt = ac;
    e_nxt  = e;
    case (op)
      OP_ADD:     {e_nxt, ac_nxt} = sum;
      OP_LOAD:    ac_nxt = data;
      OP_CLR_AC:  ac_nxt = '0;
      OP_CLR_E:   e_nxt  = 1'b0;
      OP_COMP_AC: ac_nxt = ~ac;
      OP_LOAD_AC: ac_nxt = {{(DWIDTH-8){1'b0}}, imm};
      OP_CIR_R: begin
        ac_nxt = {e, ac[DWIDTH-1:1]};
        e_nxt  = ac[0];
      end
      OP_CIR_L: begin
        ac_nxt = {ac[DWIDTH-2:0], e};
        e_nxt  = ac[DWIDTH-1];
      end
      OP_INC_AC:  ac_nxt = ac + ONE;
      default:    ;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute unit: accepts one operation per execute request from the control
// unit, performs the memory handshake it needs, updates AC/E and reports
// completion. Optional feature: define EXEC_ISZ_EN to enable the ISZ
// (increment-and-skip-if-zero) memory op; otherwise i_isz is ignored.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_execute,
  input  logic                  i_add,
  input  logic                  i_load,
  input  logic                  i_store,
  input  logic                  i_branch,
  input  logic                  i_isz,
  input  logic                  i_clr_ac,
  input  logic                  i_clr_e,
  input  logic                  i_comp_ac,
  input  logic                  i_load_ac,
  input  logic                  i_cir_r,
  input  logic                  i_cir_l,
  input  logic                  i_inc_ac,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_imm,
  exec_if.master                mem,
  output logic [DWIDTH-1:0]     o_ac,
  output logic                  o_e,
  output logic                  o_ex_done,
  output logic                  o_pc_load,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic                  o_skip
);

  state_t                state;
  op_t                   op_q;
  op_t                   op_sel;
  op_t                   alu_op;
  logic                  isz_stb;
  logic [11:0]           stb;
  logic [DWIDTH-1:0]     ac;
  logic                  e;
  logic [DWIDTH-1:0]     data_q;
  logic                  rd;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0]     mem_wdata;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_target;
  logic                  skip;
  logic                  ex_done;
  logic [DWIDTH-1:0]     alu_ac;
  logic                  alu_e;
  logic [DWIDTH-1:0]     alu_tmp;

`ifdef EXEC_ISZ_EN
  assign isz_stb = i_isz;
`else
  logic unused_isz;
  assign unused_isz = i_isz;
  assign isz_stb    = 1'b0;
`endif

  assign stb = {i_inc_ac, i_cir_l, i_cir_r, i_load_ac, i_comp_ac, i_clr_e,
                i_clr_ac, isz_stb, i_branch, i_store, i_load, i_add};
  assign op_sel = op_select(stb);

  // Register-reference ops are applied on the dispatch cycle, before op_q
  // is loaded, so the ALU sees the freshly decoded op while idle.
  assign alu_op = (state == ST_IDLE) ? op_sel : op_q;

  exec_alu #(
    .DWIDTH (DWIDTH)
  ) u_alu (
    .op     (alu_op),
    .ac     (ac),
    .e      (e),
    .data   (data_q),
    .imm    (i_imm),
    .ac_nxt (alu_ac),
    .e_nxt  (alu_e),
    .tmp    (alu_tmp)
  );

  // Sequencer: dispatch, memory handshake, AC/E update and one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_NONE;
      ac        <= '0;
      e         <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      skip      <= 1'b0;
      ex_done   <= 1'b0;
    end else begin
      pc_load <= 1'b0;
      skip    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_execute) begin
            op_q <= op_sel;
            case (op_sel)
              OP_ADD, OP_LOAD, OP_ISZ: begin
                rd       <= 1'b1;
                mem_addr <= i_addr;
                state    <= ST_MEM_RD;
              end
              OP_STORE: begin
                wr        <= 1'b1;
                mem_addr  <= i_addr;
                mem_wdata <= ac;
                state     <= ST_MEM_WR;
              end
              OP_BRANCH: begin
                pc_load   <= 1'b1;
                pc_target <= i_addr;
                ex_done   <= 1'b1;
                state     <= ST_DONE;
              end
              default: begin
                // Register ops and the empty request; the ALU passes AC/E
                // through unchanged for OP_NONE.
                ac      <= alu_ac;
                e       <= alu_e;
                ex_done <= 1'b1;
                state   <= ST_DONE;
              end
            endcase
          end
        end
        ST_MEM_RD: begin
          if (mem.i_mem_ready) begin
            rd    <= 1'b0;
            state <= ST_ALU;
          end
        end
        ST_ALU: begin
          if (op_q == OP_ISZ) begin
            wr        <= 1'b1;
            mem_wdata <= alu_tmp;
            state     <= ST_MEM_WR;
          end else begin
            ac      <= alu_ac;
            e       <= alu_e;
            ex_done <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_MEM_WR: begin
          if (mem.i_mem_ready) begin
            wr      <= 1'b0;
            ex_done <= 1'b1;
            state   <= ST_DONE;
`ifdef EXEC_ISZ_EN
            skip    <= (op_q == OP_ISZ) && (mem_wdata == '0);
`endif
          end
        end
        ST_DONE: begin
          if (!i_execute) begin
            ex_done <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture on the cycle memory answers; not part of reset state.
  always_ff @(posedge clk) begin
    if (state == ST_MEM_RD && mem.i_mem_ready) begin
      data_q <= mem.i_mem_rdata;
    end
  end

  assign mem.o_mem_read  = rd;
  assign mem.o_mem_write = wr;
  assign mem.o_mem_addr  = mem_addr;
  assign mem.o_mem_wdata = mem_wdata;

  assign o_ac        = ac;
  assign o_e         = e;
  assign o_ex_done   = ex_done;
  assign o_pc_load   = pc_load;
  assign o_pc_target = pc_target;
  assign o_skip      = skip;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed and randomized operations checked against an
// arithmetic reference model of AC/E and the expected bus activity.
module tb_exec_unit;

  localparam int DW = 16;
  localparam int AW = 12;

  localparam logic [11:0] S_ADD    = 12'h001;
  localparam logic [11:0] S_LOAD   = 12'h002;
  localparam logic [11:0] S_STORE  = 12'h004;
  localparam logic [11:0] S_BRANCH = 12'h008;
  localparam logic [11:0] S_ISZ    = 12'h010;
  localparam logic [11:0] S_CLR_AC = 12'h020;
  localparam logic [11:0] S_CLR_E  = 12'h040;
  localparam logic [11:0] S_COMP   = 12'h080;
  localparam logic [11:0] S_LDAC   = 12'h100;
  localparam logic [11:0] S_CIR_R  = 12'h200;
  localparam logic [11:0] S_CIR_L  = 12'h400;
  localparam logic [11:0] S_INC    = 12'h800;

  typedef struct {
    int ac;
    int e;
    int rd;
    int wr;
    int wdata;
    int pcl;
    int skip;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic i_execute;
  logic [11:0] stb;
  logic i_add, i_load, i_store, i_branch, i_isz;
  logic i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac;
  logic [AW-1:0] i_addr;
  logic [7:0] i_imm;
  logic [DW-1:0] o_ac;
  logic o_e, o_ex_done, o_pc_load, o_skip;
  logic [AW-1:0] o_pc_target;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  int rd_val = 0;
  int wait_cnt = 0;
  int rd_cyc = 0, wr_cyc = 0, both_cyc = 0, pcl_cyc = 0, skip_cyc = 0;
  int rd_addr_l = 0, wr_addr_l = 0, wr_data_l = 0, pc_tgt_l = 0;
  int m_ac = 0, m_e = 0;

  always #5 clk = ~clk;

  assign {i_inc_ac, i_cir_l, i_cir_r, i_load_ac, i_comp_ac, i_clr_e,
          i_clr_ac, i_isz, i_branch, i_store, i_load, i_add} = stb;

  exec_if #(.DWIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  exec_unit #(.DWIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_execute   (i_execute),
    .i_add       (i_add),
    .i_load      (i_load),
    .i_store     (i_store),
    .i_branch    (i_branch),
    .i_isz       (i_isz),
    .i_clr_ac    (i_clr_ac),
    .i_clr_e     (i_clr_e),
    .i_comp_ac   (i_comp_ac),
    .i_load_ac   (i_load_ac),
    .i_cir_r     (i_cir_r),
    .i_cir_l     (i_cir_l),
    .i_inc_ac    (i_inc_ac),
    .i_addr      (i_addr),
    .i_imm       (i_imm),
    .mem         (mif),
    .o_ac        (o_ac),
    .o_e         (o_e),
    .o_ex_done   (o_ex_done),
    .o_pc_load   (o_pc_load),
    .o_pc_target (o_pc_target),
    .o_skip      (o_skip)
  );

  // Memory responder (ready after lat cycles of request) and bus monitor.
  always @(negedge clk) begin
    if ((mif.o_mem_read || mif.o_mem_write) && !mif.i_mem_ready) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= lat) begin
        mif.i_mem_ready = 1'b1;
        mif.i_mem_rdata = rd_val[15:0];
      end
    end else begin
      wait_cnt        = 0;
      mif.i_mem_ready = 1'b0;
      mif.i_mem_rdata = 16'($urandom);
    end
    if (mif.o_mem_read) begin
      rd_cyc    = rd_cyc + 1;
      rd_addr_l = 32'(mif.o_mem_addr);
    end
    if (mif.o_mem_write) begin
      wr_cyc    = wr_cyc + 1;
      wr_addr_l = 32'(mif.o_mem_addr);
      wr_data_l = 32'(mif.o_mem_wdata);
    end
    if (mif.o_mem_read && mif.o_mem_write) both_cyc = both_cyc + 1;
    if (o_pc_load) begin
      pcl_cyc  = pcl_cyc + 1;
      pc_tgt_l = 32'(o_pc_target);
    end
    if (o_skip) skip_cyc = skip_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one request, from the architectural rules.
  function automatic res_t model(input logic [11:0] s_in, input int ac, input int e,
                                 input int mv, input int imm);
    res_t r;
    logic [11:0] s;
    int k;
    s = s_in;
`ifndef EXEC_ISZ_EN
    s[4] = 1'b0;
`endif
    r.ac = ac; r.e = e; r.rd = 0; r.wr = 0; r.wdata = 0; r.pcl = 0; r.skip = 0;
    k = -1;
    for (int i = 11; i >= 0; i--) if (s[i]) k = i;
    case (k)
      0: begin r.rd = 1; r.ac = (ac + mv) % 65536; r.e = (ac + mv) / 65536; end
      1: begin r.rd = 1; r.ac = mv; end
      2: begin r.wr = 1; r.wdata = ac; end
      3: r.pcl = 1;
      4: begin
        r.rd = 1; r.wr = 1; r.wdata = (mv + 1) % 65536;
        r.skip = (r.wdata == 0) ? 1 : 0;
      end
      5: r.ac = 0;
      6: r.e = 0;
      7: r.ac = 65535 - ac;
      8: r.ac = imm;
      9: begin r.ac = e * 32768 + ac / 2; r.e = ac % 2; end
      10: begin r.ac = (ac % 32768) * 2 + e; r.e = ac / 32768; end
      11: r.ac = (ac + 1) % 65536;
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [11:0] s, input int addr,
                        input int imm, input int mv, input int l, input bit hold);
    res_t r;
    int b_rd, b_wr, b_both, b_pcl, b_skip;
    bit got;
    r = model(s, m_ac, m_e, mv, imm);
    lat = l;
    rd_val = mv;
    b_rd = rd_cyc; b_wr = wr_cyc; b_both = both_cyc; b_pcl = pcl_cyc; b_skip = skip_cyc;
    @(posedge clk); #1;
    i_execute = 1'b1;
    stb       = s;
    i_addr    = addr[AW-1:0];
    i_imm     = imm[7:0];
    @(posedge clk); #1;
    // Request already latched: scramble the operands to prove it.
    stb    = 12'($urandom);
    i_addr = 12'($urandom);
    i_imm  = 8'($urandom);
    if (!hold) i_execute = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk); #1;
      if (o_ex_done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 1);
    i_execute = 1'b0;
    stb       = '0;
    @(negedge clk); #1;
    check({tag, "_done_low"}, 32'(o_ex_done), 0);
    check({tag, "_ac"}, 32'(o_ac), r.ac);
    check({tag, "_e"}, 32'(o_e), r.e);
    check({tag, "_rd_cycles"}, rd_cyc - b_rd, r.rd ? l : 0);
    check({tag, "_wr_cycles"}, wr_cyc - b_wr, r.wr ? l : 0);
    check({tag, "_rd_wr_overlap"}, both_cyc - b_both, 0);
    check({tag, "_pc_load_cycles"}, pcl_cyc - b_pcl, r.pcl);
    check({tag, "_skip_cycles"}, skip_cyc - b_skip, r.skip);
    if (r.rd != 0) check({tag, "_rd_addr"}, rd_addr_l, addr % 4096);
    if (r.wr != 0) begin
      check({tag, "_wr_addr"}, wr_addr_l, addr % 4096);
      check({tag, "_wr_data"}, wr_data_l, r.wdata);
    end
    if (r.pcl != 0) check({tag, "_pc_target"}, pc_tgt_l, addr % 4096);
    m_ac = r.ac;
    m_e  = r.e;
  endtask

  initial begin
    reset     = 1'b1;
    i_execute = 1'b0;
    stb       = '0;
    i_addr    = '0;
    i_imm     = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ac", 32'(o_ac), 0);
    check("rst_e", 32'(o_e), 0);
    check("rst_done", 32'(o_ex_done), 0);
    check("rst_rd", 32'(mif.o_mem_read), 0);
    check("rst_wr", 32'(mif.o_mem_write), 0);
    check("rst_addr", 32'(mif.o_mem_addr), 0);
    check("rst_wdata", 32'(mif.o_mem_wdata), 0);
    check("rst_pc_load", 32'(o_pc_load), 0);
    check("rst_pc_target", 32'(o_pc_target), 0);
    check("rst_skip", 32'(o_skip), 0);
    @(negedge clk);
    reset = 1'b0;

    // AC=FFFF, E=0, add 1 with 3-cycle memory: carries out into E.
    run_op("clr_ac", S_CLR_AC, 0, 0, 0, 1, 1'b1);
    run_op("clr_e", S_CLR_E, 0, 0, 0, 1, 1'b1);
    run_op("comp_ac", S_COMP, 0, 0, 0, 1, 1'b1);
    check("comp_ac_ffff", 32'(o_ac), 32'h0000_FFFF);
    run_op("add_carry", S_ADD, 12'h123, 0, 1, 3, 1'b1);
    check("add_carry_ac0", 32'(o_ac), 0);
    check("add_carry_e1", 32'(o_e), 1);

    // Rotates through E.
    run_op("load_8001", S_LOAD, 12'h200, 0, 16'h8001, 2, 1'b1);
    run_op("clr_e2", S_CLR_E, 0, 0, 0, 1, 1'b1);
    run_op("cir_l", S_CIR_L, 0, 0, 0, 1, 1'b1);
    check("cir_l_ac", 32'(o_ac), 32'h0002);
    check("cir_l_e", 32'(o_e), 1);
    run_op("cir_r", S_CIR_R, 0, 0, 0, 1, 1'b1);
    check("cir_r_ac", 32'(o_ac), 32'h8001);
    check("cir_r_e", 32'(o_e), 0);

    // Increment wraps, immediate load, store.
    run_op("comp2", S_COMP, 0, 0, 0, 1, 1'b1);
    run_op("comp3", S_COMP, 0, 0, 0, 1, 1'b0);
    run_op("clr_ac2", S_CLR_AC, 0, 0, 0, 1, 1'b1);
    run_op("comp4", S_COMP, 0, 0, 0, 1, 1'b1);
    run_op("inc_wrap", S_INC, 0, 0, 0, 1, 1'b1);
    check("inc_wrap_ac", 32'(o_ac), 0);
    run_op("load_ac", S_LDAC, 0, 8'hA5, 0, 1, 1'b1);
    check("load_ac_val", 32'(o_ac), 32'h00A5);
    run_op("store", S_STORE, 12'h7FE, 0, 0, 2, 1'b1);

    // Increment-and-skip.
    run_op("isz_ffff", S_ISZ, 12'h010, 0, 16'hFFFF, 2, 1'b1);
    run_op("isz_0005", S_ISZ, 12'h011, 0, 16'h0005, 1, 1'b1);
`ifdef EXEC_ISZ_EN
    check("isz_0005_wdata", 32'(wr_data_l), 32'h0006);
`endif

    // Branch, priority, empty request, abort-free drop of execute.
    run_op("branch", S_BRANCH, 12'h3A5, 0, 0, 1, 1'b1);
    check("branch_target", 32'(o_pc_target), 32'h03A5);
    run_op("add_over_load", S_ADD | S_LOAD, 12'h044, 0, 16'h1234, 2, 1'b1);
    run_op("no_strobe", 12'h000, 12'h055, 0, 0, 1, 1'b1);
    run_op("add_drop_exec", S_ADD, 12'h066, 0, 16'h0F0F, 4, 1'b0);
    run_op("store_drop_exec", S_STORE, 12'h077, 0, 0, 3, 1'b0);

    // Randomized requests.
    for (int n = 0; n < 80; n++) begin
      logic [11:0] s;
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        1:       s = 12'($urandom);
        2:       s = '0;
        default: s = 12'(1 << $urandom_range(0, 11));
      endcase
      run_op("rand", s, $urandom_range(0, 4095), $urandom_range(0, 255),
             $urandom_range(0, 65535), $urandom_range(1, 4), 1'($urandom));
    end

    // Asynchronous reset in the middle of a write.
    run_op("pre_rst_ldac", S_LDAC, 0, 8'h77, 0, 1, 1'b1);
    lat = 20;
    @(posedge clk); #1;
    i_execute = 1'b1;
    stb       = S_STORE;
    i_addr    = 12'h0F0;
    repeat (4) @(negedge clk);
    #1;
    check("midwr_write_high", 32'(mif.o_mem_write), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midwr_write_drop", 32'(mif.o_mem_write), 0);
    check("midwr_read", 32'(mif.o_mem_read), 0);
    check("midwr_ac", 32'(o_ac), 0);
    check("midwr_e", 32'(o_e), 0);
    check("midwr_done", 32'(o_ex_done), 0);
    check("midwr_addr", 32'(mif.o_mem_addr), 0);
    check("midwr_wdata", 32'(mif.o_mem_wdata), 0);
    i_execute = 1'b0;
    stb       = '0;
    m_ac      = 0;
    m_e       = 0;
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst_ldac", S_LDAC, 0, 8'h3C, 0, 1, 1'b1);
    run_op("post_rst_add", S_ADD, 12'h101, 0, 16'h0100, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
